// File: rtl/debug_status_writer.sv
// debug_status_writer: producer side of the visuMon debug-LED interface.
// Queues LED status updates in a small FIFO, drops writes that would not
// change the LED (per-LED shadow copy) and emits each remaining update as a
// debugInfo word framed by an active-low chip select.
//
// Ports:
//   i_clk25Mhz   system clock (25 MHz)
//   i_reset      synchronous reset, active-high
//   i_valid      request valid
//   o_ready      FIFO not full (combinational from FIFO count)
//   i_ledNo      LED index of request
//   i_color      colour code: 0 red, 1 green, 2 blue, 3 yellow
//   i_status     1 = LED on, 0 = off
//   o_cs         visuMon chip select, active-low
//   o_ledNo      debugInfo.ledNo
//   o_color      debugInfo.color
//   o_status     debugInfo.status
//   o_busy       writer active or FIFO not empty
//   o_dropCount  saturating count of rejected requests
module debug_status_writer #(
    parameter int unsigned NUM_LEDS    = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       i_clk25Mhz,
    input  logic       i_reset,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [3:0] i_ledNo,
    input  logic [1:0] i_color,
    input  logic       i_status,
    output logic       o_cs,
    output logic [3:0] o_ledNo,
    output logic [1:0] o_color,
    output logic       o_status,
    output logic       o_busy,
    output logic [7:0] o_dropCount
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(HOLD_CYCLES + GAP_CYCLES + 1);
    localparam int unsigned ENTRY_W = 7;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    // FIFO storage: entry = {ledNo, color, status}
    logic [FIFO_DEPTH-1:0][ENTRY_W-1:0] r_mem;
    logic [PTR_W-1:0]                   r_wr_ptr;
    logic [PTR_W-1:0]                   r_rd_ptr;
    logic [PTR_W:0]                     r_count;

    state_t                             r_state;
    logic [CNT_W-1:0]                   r_cnt;

    // Shadow sized for the full 4-bit index space so lookups never go out of range
    logic [15:0]                        r_shadow_valid;
    logic [15:0]                        r_shadow_status;
    logic [15:0][1:0]                   r_shadow_color;

    logic                               w_full;
    logic                               w_empty;
    logic                               w_idx_ok;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_drop;
    logic                               w_match;
    logic [ENTRY_W-1:0]                 w_head;

    assign w_full   = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign o_ready  = !w_full;
    assign w_idx_ok = (32'(i_ledNo) < NUM_LEDS);
    assign w_push   = i_valid && !w_full && w_idx_ok;
    // Out-of-range index is consumed but counted; valid while full is refused and counted
    assign w_drop   = i_valid && (w_full || !w_idx_ok);
    assign w_pop    = (r_state == IDLE) && !w_empty;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_match  = r_shadow_valid[w_head[6:3]]
                   && (r_shadow_color[w_head[6:3]] == w_head[2:1])
                   && (r_shadow_status[w_head[6:3]] == w_head[0]);

    // FIFO data array (no reset needed; qualified by count)
    always_ff @(posedge i_clk25Mhz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_ledNo, i_color, i_status};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk25Mhz) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    // Saturating drop counter
    always_ff @(posedge i_clk25Mhz) begin
        if (i_reset) begin
            o_dropCount <= '0;
        end else if (w_drop && (o_dropCount != 8'hFF)) begin
            o_dropCount <= o_dropCount + 8'd1;
        end
    end

    // Write sequencer; o_cs/o_busy are registered from the current state,
    // so the strobe appears on the pins one cycle after the state enters STROBE
    always_ff @(posedge i_clk25Mhz) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            o_cs            <= 1'b1;
            o_ledNo         <= '0;
            o_color         <= '0;
            o_status        <= 1'b0;
            o_busy          <= 1'b0;
            r_shadow_valid  <= '0;
            r_shadow_status <= '0;
            r_shadow_color  <= '0;
        end else begin
            o_cs   <= (r_state != STROBE);
            o_busy <= (r_state != IDLE) || !w_empty;
            case (r_state)
                IDLE: begin
                    // Matching entries are discarded here at one per cycle
                    if (!w_empty && !w_match) begin
                        o_ledNo  <= w_head[6:3];
                        o_color  <= w_head[2:1];
                        o_status <= w_head[0];
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_cnt   <= '0;
                    r_state <= STROBE;
                end
                STROBE: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        r_shadow_valid[o_ledNo]  <= 1'b1;
                        r_shadow_color[o_ledNo]  <= o_color;
                        r_shadow_status[o_ledNo] <= o_status;
                        r_cnt                    <= '0;
                        r_state                  <= GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
